core_lsu_ctrl: RTL and testbench
================================

// Module: core_lsu_ctrl
// PURPOSE
//  Load/store sequencer between the MEM stage and Data_Memory. Takes the MEM-stage access (ALU address, rs2 data,
//  funct3), runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until it finishes.
//  Generates byte-lane strobes and shifted write data, and sign/zero-extends load data. Flags misaligned/illegal accesses.
// PARAMETERS
//  XLEN    64  data width; byte-lane math is fixed at 8 lanes, only 64 is legal
//  ADDR_W  32  data-memory address width; dm_addr_o = {addr_i[ADDR_W-1:3],3'b000}
// PORTS
//  clk         in   1       core clock
//  rst_n       in   1       asynchronous active-low reset
//  mem_valid_i in   1       MEM stage holds a valid instruction
//  is_load_i   in   1       instruction is a load
//  is_store_i  in   1       instruction is a store
//  funct3_i    in   3       RV64 width/sign code (LB..LWU, SB..SD)
//  addr_i      in   XLEN    effective address (ALU result)
//  wdata_i     in   XLEN    store data (rs2)
//  flush_i     in   1       kill current MEM-stage instruction
//  stall_o     out  1       hold IF..MEM stages this cycle
//  done_o      out  1       1-cycle pulse: access complete; rdata_o valid in same cycle
//  rdata_o     out  XLEN    extended load data (0 for stores)
//  err_o       out  1       1-cycle pulse: misaligned/illegal access; no memory request issued
//  dm_req_o    out  1       memory request, held high until dm_ack_i
//  dm_we_o     out  1       1 = write
//  dm_addr_o   out  ADDR_W  doubleword-aligned address
//  dm_wdata_o  out  XLEN    wdata_i << 8*addr_i[2:0]
//  dm_wstrb_o  out  8       byte enables (0 for loads)
//  dm_ack_i    in   1       memory accepted/finished; dm_rdata_i valid with it
//  dm_rdata_i  in   XLEN    raw doubleword read data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; every output 0; drop flag cleared. Memory resets with the core.
//  FSM IDLE/WAIT/RESP. start = mem_valid_i & (is_load_i ^ is_store_i) & ~flush_i & legal & aligned.
//  IDLE: start -> latch addr/wdata/funct3/we, stall_o=1 (combinational), next WAIT. Otherwise stall_o=0.
//  WAIT: dm_req_o=1 and dm_* outputs driven from latches, stable until ack. stall_o=1.
//   dm_ack_i=1 -> register extended rdata, next RESP (or IDLE if drop set). dm_ack_i=0 -> stay.
//  RESP: done_o=1, stall_o=0, dm_req_o=0; pipeline advances at this edge; next IDLE.
//  Minimum latency: ack in first WAIT cycle -> detect C0, req C1, done C2 (2 stall cycles).
//  Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0, B always aligned.
//  Legal funct3: loads 0,1,2,3,4,5,6; stores 0,1,2,3. Load f3=7, store f3>=4, or is_load&is_store -> illegal.
//  Misaligned/illegal in IDLE with mem_valid_i & ~flush_i: err_o=1 that cycle, no req, no stall, stay IDLE.
//  Strobes: SB 8'h01<<a, SH 8'h03<<a, SW 8'h0F<<a, SD 8'hFF; a=addr[2:0].
//  Load: s = dm_rdata_i >> 8*a; LB/LH/LW sign-extend s[7:0]/[15:0]/[31:0]; LBU/LHU/LWU zero-extend; LD = s.
//  flush_i in IDLE: no access started. flush_i in WAIT: request NOT withdrawn; set drop; keep stall_o=1 until ack,
//   then return to IDLE with no done_o and rdata_o unchanged. flush_i in RESP: ignored (access already complete).
//  rdata_o holds last load value until next load completes; updated only on load ack.
// TESTING
//  SD addr=0x1000 wdata=0x1122334455667788, ack after 3 cycles -> wstrb=FF, addr=0x1000, stall 4 cycles, done 1 pulse.
//  SB addr=0x1005 wdata=0xAB -> wstrb=0x20, wdata byte5=0xAB, we=1; ack same cycle as req -> done at C2.
//  LB addr=0x2003, rdata=0x00000000_80000000 -> rdata_o=0xFFFFFFFFFFFFFF80; LBU same -> 0x80; LWU addr 0x2000 -> 0x80000000.
//  LW addr=0x3002 -> err_o pulse 1 cycle, dm_req_o stays 0, stall_o 0; store f3=5 -> err_o pulse.
//  Load in WAIT, flush_i pulse, ack 2 cycles later -> stall held until ack, no done_o, rdata_o unchanged, IDLE next.
//  rst_n low during WAIT -> dm_req_o/stall_o drop immediately; after release, fresh LD completes normally.

Source files
------------

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl: MEM-stage load/store sequencer with req/ack data-memory handshake
module core_lsu_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [XLEN-1:0]   dm_wdata_o,
  output logic [7:0]        dm_wstrb_o,
  input  logic              dm_ack_i,
  input  logic [XLEN-1:0]   dm_rdata_i
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic drop, acc, legal, aligned, start, kill;
  logic [2:0] f3, off;
  logic [7:0] strb;
  logic [XLEN-1:0] s, ext;
  logic unused_addr;
  assign unused_addr = ^addr_i[XLEN-1:ADDR_W];
  // access decode: legality, alignment, strobes and load extension
  always_comb begin
    acc     = mem_valid_i & ~flush_i & (is_load_i | is_store_i);
    legal   = (is_load_i ^ is_store_i) & (is_load_i ? funct3_i != 3'd7 : ~funct3_i[2]);
    aligned = funct3_i[1:0] == 2'd0 ? 1'b1 :
              funct3_i[1:0] == 2'd1 ? ~addr_i[0] :
              funct3_i[1:0] == 2'd2 ? addr_i[1:0] == 2'd0 : addr_i[2:0] == 3'd0;
    start   = state == IDLE & acc & legal & aligned;
    err_o   = rst_n & state == IDLE & acc & ~(legal & aligned);
    stall_o = rst_n & (start | state == WAIT);
    kill    = drop | flush_i;
    strb    = funct3_i[1:0] == 2'd0 ? 8'h01 << addr_i[2:0] :
              funct3_i[1:0] == 2'd1 ? 8'h03 << addr_i[2:0] :
              funct3_i[1:0] == 2'd2 ? 8'h0F << addr_i[2:0] : 8'hFF;
    s       = dm_rdata_i >> {off, 3'b000};
    ext     = f3 == 3'd0 ? {{(XLEN-8){s[7]}}, s[7:0]} :
              f3 == 3'd1 ? {{(XLEN-16){s[15]}}, s[15:0]} :
              f3 == 3'd2 ? {{(XLEN-32){s[31]}}, s[31:0]} :
              f3 == 3'd4 ? {{(XLEN-8){1'b0}}, s[7:0]} :
              f3 == 3'd5 ? {{(XLEN-16){1'b0}}, s[15:0]} :
              f3 == 3'd6 ? {{(XLEN-32){1'b0}}, s[31:0]} : s;
  end
  // handshake FSM; a flushed access still waits for its ack but retires silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      f3         <= 3'd0;
      off        <= 3'd0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_wdata_o <= '0;
      dm_wstrb_o <= 8'h00;
    end else if (state == IDLE) begin
      if (start) begin
        state      <= WAIT;
        drop       <= 1'b0;
        f3         <= funct3_i;
        off        <= addr_i[2:0];
        dm_req_o   <= 1'b1;
        dm_we_o    <= is_store_i;
        dm_addr_o  <= {addr_i[ADDR_W-1:3], 3'b000};
        dm_wdata_o <= wdata_i << {addr_i[2:0], 3'b000};
        dm_wstrb_o <= is_store_i ? strb : 8'h00;
      end
    end else if (state == WAIT) begin
      if (flush_i) drop <= 1'b1;
      if (dm_ack_i) begin
        dm_req_o <= 1'b0;
        done_o   <= ~kill;
        state    <= kill ? IDLE : RESP;
        if (!dm_we_o && !kill) rdata_o <= ext;
      end
    end else begin
      done_o <= 1'b0;
      state  <= IDLE;
    end
  end
endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl: directed-vector bench for the load/store sequencer
module tb_core_lsu_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid_i = 1'b0, is_load_i = 1'b0, is_store_i = 1'b0, flush_i = 1'b0, dm_ack_i = 1'b0;
  logic [2:0] funct3_i = 3'd0;
  logic [63:0] addr_i = '0, wdata_i = '0, dm_rdata_i = '0;
  logic stall_o, done_o, err_o, dm_req_o, dm_we_o;
  logic [63:0] rdata_o, dm_wdata_o;
  logic [31:0] dm_addr_o;
  logic [7:0] dm_wstrb_o;
  int nvec = 0, nerr = 0;
  int stalls, dones, done_at;
  logic [7:0] c_strb;
  logic [63:0] c_wdata;
  logic [31:0] c_addr;
  logic c_we;

  core_lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
    .dm_wstrb_o(dm_wstrb_o), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] w);
    mem_valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = w;
  endtask

  // runs one access already driven this cycle; ack on the waits-th request cycle
  task automatic access(input int waits);
    int w = 0;
    logic got = 1'b0;
    stalls = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      dm_ack_i = dm_req_o && (w == waits - 1);
      if (dm_req_o) begin
        if (!got) begin
          c_strb = dm_wstrb_o; c_wdata = dm_wdata_o; c_addr = dm_addr_o; c_we = dm_we_o;
        end
        got = 1'b1;
        w++;
      end
      #1;
      if (stall_o) stalls++;
      if (done_o) begin dones++; done_at = i; end
      @(posedge clk); #1;
      mem_valid_i = 1'b0; dm_ack_i = 1'b0;
    end
    chk("req_seen", {63'd0, got}, 64'd1);
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd2, 64'h3002, 64'h0);
    #2;
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_req", {63'd0, dm_req_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_wstrb", {56'd0, dm_wstrb_o}, 64'd0);
    mem_valid_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // SD, 3 wait cycles
    drive(1'b0, 1'b1, 3'd3, 64'h1000, 64'h1122334455667788);
    #1 chk("sd_c0_stall", {63'd0, stall_o}, 64'd1);
    chk("sd_c0_req", {63'd0, dm_req_o}, 64'd0);
    access(3);
    chk("sd_strb", {56'd0, c_strb}, 64'hFF);
    chk("sd_addr", {32'd0, c_addr}, 64'h1000);
    chk("sd_wdata", c_wdata, 64'h1122334455667788);
    chk("sd_we", {63'd0, c_we}, 64'd1);
    chk("sd_stalls", stalls, 4);
    chk("sd_dones", dones, 1);
    chk("sd_done_at", done_at, 4);
    // SB at byte 5, immediate ack
    drive(1'b0, 1'b1, 3'd0, 64'h1005, 64'hAB);
    access(1);
    chk("sb_strb", {56'd0, c_strb}, 64'h20);
    chk("sb_wdata", c_wdata, 64'h0000AB0000000000);
    chk("sb_addr", {32'd0, c_addr}, 64'h1000);
    chk("sb_we", {63'd0, c_we}, 64'd1);
    chk("sb_stalls", stalls, 2);
    chk("sb_done_at", done_at, 2);
    // loads
    dm_rdata_i = 64'h0000000080000000;
    drive(1'b1, 1'b0, 3'd0, 64'h2003, 64'h0);
    access(2);
    chk("lb_rdata", rdata_o, 64'hFFFFFFFFFFFFFF80);
    chk("lb_strb", {56'd0, c_strb}, 64'h00);
    chk("lb_we", {63'd0, c_we}, 64'd0);
    chk("lb_dones", dones, 1);
    drive(1'b1, 1'b0, 3'd4, 64'h2003, 64'h0);
    access(1);
    chk("lbu_rdata", rdata_o, 64'h80);
    drive(1'b1, 1'b0, 3'd1, 64'h2002, 64'h0);
    access(1);
    chk("lh_rdata", rdata_o, 64'hFFFFFFFFFFFF8000);
    drive(1'b1, 1'b0, 3'd2, 64'h2000, 64'h0);
    access(1);
    chk("lw_rdata", rdata_o, 64'hFFFFFFFF80000000);
    drive(1'b1, 1'b0, 3'd6, 64'h2000, 64'h0);
    access(1);
    chk("lwu_rdata", rdata_o, 64'h80000000);
    // error cases
    drive(1'b1, 1'b0, 3'd2, 64'h3002, 64'h0);
    #1 chk("lw_mis_err", {63'd0, err_o}, 64'd1);
    chk("lw_mis_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 mem_valid_i = 1'b0;
    #1 chk("lw_mis_req", {63'd0, dm_req_o}, 64'd0);
    chk("lw_mis_err_off", {63'd0, err_o}, 64'd0);
    drive(1'b0, 1'b1, 3'd5, 64'h3000, 64'h0);
    #1 chk("st_f3_err", {63'd0, err_o}, 64'd1);
    chk("st_f3_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 drive(1'b1, 1'b1, 3'd0, 64'h3000, 64'h0);
    #1 chk("ldst_err", {63'd0, err_o}, 64'd1);
    @(posedge clk); #1 drive(1'b0, 1'b1, 3'd1, 64'h3001, 64'h0);
    #1 chk("sh_mis_err", {63'd0, err_o}, 64'd1);
    @(posedge clk); #1 drive(1'b1, 1'b0, 3'd7, 64'h3000, 64'h0);
    #1 chk("ld_f3_7_err", {63'd0, err_o}, 64'd1);
    @(posedge clk); #1 drive(1'b1, 1'b0, 3'd3, 64'h3000, 64'h0); flush_i = 1'b1;
    #1 chk("idle_flush_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 mem_valid_i = 1'b0; flush_i = 1'b0;
    #1 chk("idle_flush_req", {63'd0, dm_req_o}, 64'd0);
    // flush while waiting
    dm_rdata_i = 64'h12345678;
    drive(1'b1, 1'b0, 3'd2, 64'h2000, 64'h0);
    #1 chk("fl_c0_stall", {63'd0, stall_o}, 64'd1);
    @(posedge clk); #1 mem_valid_i = 1'b0; flush_i = 1'b1;
    #1 chk("fl_c1_req", {63'd0, dm_req_o}, 64'd1);
    chk("fl_c1_stall", {63'd0, stall_o}, 64'd1);
    @(posedge clk); #1 flush_i = 1'b0;
    #1 chk("fl_c2_req", {63'd0, dm_req_o}, 64'd1);
    chk("fl_c2_stall", {63'd0, stall_o}, 64'd1);
    @(posedge clk); #1 dm_ack_i = 1'b1;
    #1 chk("fl_c3_stall", {63'd0, stall_o}, 64'd1);
    @(posedge clk); #1 dm_ack_i = 1'b0;
    #1 chk("fl_c4_done", {63'd0, done_o}, 64'd0);
    chk("fl_c4_stall", {63'd0, stall_o}, 64'd0);
    chk("fl_c4_req", {63'd0, dm_req_o}, 64'd0);
    chk("fl_rdata", rdata_o, 64'h80000000);
    @(posedge clk); #2 chk("fl_c5_done", {63'd0, done_o}, 64'd0);
    // reset during WAIT
    @(posedge clk); #1 drive(1'b1, 1'b0, 3'd3, 64'h2008, 64'h0);
    @(posedge clk); #1 mem_valid_i = 1'b0;
    #1 chk("rw_req", {63'd0, dm_req_o}, 64'd1);
    rst_n = 1'b0;
    #1 chk("rw_req_drop", {63'd0, dm_req_o}, 64'd0);
    chk("rw_stall_drop", {63'd0, stall_o}, 64'd0);
    chk("rw_rdata", rdata_o, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dm_rdata_i = 64'h0123456789ABCDEF;
    drive(1'b1, 1'b0, 3'd3, 64'h2008, 64'h0);
    access(2);
    chk("ld_rdata", rdata_o, 64'h0123456789ABCDEF);
    chk("ld_addr", {32'd0, c_addr}, 64'h2008);
    chk("ld_stalls", stalls, 3);
    chk("ld_dones", dones, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
